// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver, LSB first, 16x oversampling with
// mid-bit sampling, start-glitch rejection, framing/overrun pulses and a
// small ready/valid output FIFO.
module uart_rx_monitor #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4  // power of 2, >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       data_valid,
  output logic [7:0] data_bits,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned DivRaw = CLK_HZ / (BAUD * 16);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic            sync_q;
  logic            rxs_q;
  logic [CntW-1:0] cnt_q;
  logic            tick;
  state_e          state_q;
  logic [3:0]      os_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            start_det;
  logic            push;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic            ovr_q;
  logic            pop;
  logic            full;
  logic            empty;
  logic            do_write;

  // Two-flop synchronizer; resets to the idle line level so no false start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  assign start_det = (state_q == StIdle) && !rxs_q;
  assign tick      = (cnt_q == CntMax);

  // Oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start_det || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Receive FSM: start validation, data shifting, stop check, break wait.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      os_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          os_q      <= '0;
          bit_cnt_q <= '0;
          if (!rxs_q) state_q <= StStart;
        end
        StStart: begin
          if (tick) begin
            if (os_q == 4'd7) begin
              // Mid start bit: a high line here was only a glitch.
              os_q    <= '0;
              state_q <= rxs_q ? StIdle : StData;
            end else begin
              os_q <= os_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            os_q <= os_q + 4'd1;  // wraps to 0 on each bit boundary
            if (os_q == 4'd15) begin
              shift_q   <= {rxs_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (tick) begin
            os_q <= os_q + 4'd1;
            if (os_q == 4'd15) begin
              if (rxs_q) begin
                state_q <= StIdle;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StBreak;
              end
            end
          end
        end
        StBreak: begin
          os_q <= '0;
          if (rxs_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A good stop bit sampled mid-bit delivers the assembled byte.
  assign push     = (state_q == StStop) && tick && (os_q == 4'd15) && rxs_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop      = !empty && data_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_write = push && (!full || pop);

  // Output FIFO storage, pointers and overrun pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= push && full && !pop;
      if (do_write) begin
        mem_q[wptr_q[AddrW-1:0]] <= shift_q;
        wptr_q                   <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
    end
  end

  assign data_valid    = !empty;
  assign data_bits     = mem_q[rptr_q[AddrW-1:0]];
  assign framing_error = frame_err_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor at DIV=1 (16 cycles per bit). A scoreboard model
// of the FIFO, driven by frame-level events, is compared every cycle; literal
// expectations per scenario pin the model.
module tb_uart_rx_monitor;

  localparam int Depth = 4;
  localparam int Lat   = 155;  // rxd fall to data_valid, in clock cycles

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       data_ready = 1'b0;
  logic       data_valid;
  logic [7:0] data_bits;
  logic       framing_error;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Model state
  logic [7:0] mq[$];
  int         ev_due[$];
  logic [7:0] ev_byte[$];
  bit         ev_good[$];
  bit         pop_pend = 1'b0;
  bit         exp_fe;
  bit         exp_ov;

  // Observations for literal checks
  logic [7:0] got_q[$];
  int         n_fe = 0;
  int         n_ov = 0;
  int         dv_cnt = 0;
  int         rise_cyc = 0;
  int         last_fall = 0;
  bit         dv_prev = 1'b0;
  int         tgt;

  uart_rx_monitor #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rxd          (rxd),
    .data_valid   (data_valid),
    .data_bits    (data_bits),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_got(input string name, input int idx, input logic [7:0] exp);
    logic [31:0] act;
    act = (idx < got_q.size()) ? {24'd0, got_q[idx]} : 32'h100;
    chk(name, act, {24'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_stats();
    got_q.delete();
    n_fe   = 0;
    n_ov   = 0;
    dv_cnt = 0;
  endtask

  // Full 10-bit frame; registers the frame-level event the model expects.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr        = {stop_bit, b, 1'b0};
    last_fall = cyc;
    ev_due.push_back(cyc + Lat);
    ev_byte.push_back(b);
    ev_good.push_back(stop_bit);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (16) @(posedge clock);
      #1;
    end
  endtask

  // Start bit plus nbits data bits, then hold bit nbits for extra cycles.
  task automatic send_partial(input logic [7:0] b, input int nbits, input int extra);
    rxd = 1'b0;
    idle(16);
    for (int i = 0; i < nbits; i++) begin
      rxd = b[i];
      idle(16);
    end
    rxd = b[nbits];
    idle(extra);
  endtask

  // Per-cycle compare against the scoreboard model.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_valid", data_valid, 0);
      chk("rst_bits", data_bits, 0);
      chk("rst_ferr", framing_error, 0);
      chk("rst_ovr", overrun, 0);
      mq.delete();
      ev_due.delete();
      ev_byte.delete();
      ev_good.delete();
      pop_pend = 1'b0;
    end else begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (pop_pend && mq.size() > 0) void'(mq.pop_front());
      while (ev_due.size() > 0 && ev_due[0] <= cyc) begin
        if (ev_due[0] == cyc) begin
          if (!ev_good[0]) exp_fe = 1'b1;
          else if (mq.size() < Depth) mq.push_back(ev_byte[0]);
          else exp_ov = 1'b1;
        end
        void'(ev_due.pop_front());
        void'(ev_byte.pop_front());
        void'(ev_good.pop_front());
      end
      chk("valid", data_valid, mq.size() > 0);
      if (mq.size() > 0) chk("bits", data_bits, mq[0]);
      chk("ferr", framing_error, exp_fe);
      chk("ovr", overrun, exp_ov);
      if (data_valid && data_ready) got_q.push_back(data_bits);
      if (framing_error) n_fe++;
      if (overrun) n_ov++;
      if (data_valid) dv_cnt++;
      if (data_valid && !dv_prev) rise_cyc = cyc;
      dv_prev  = data_valid;
      pop_pend = (mq.size() > 0) && data_ready;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    idle(5);

    // 1: single byte, consumer ready
    clear_stats();
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(4);
    chk("t1_count", got_q.size(), 1);
    chk_got("t1_byte", 0, 8'hA5);
    chk("t1_latency", rise_cyc - last_fall, 155);
    chk("t1_dv_cycles", dv_cnt, 1);
    chk("t1_errs", n_fe + n_ov, 0);

    // 2: back-to-back burst into a stalled consumer
    clear_stats();
    data_ready = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(4);
    chk("t2_overrun", n_ov, 1);
    chk("t2_head", data_bits, 8'h00);
    data_ready = 1'b1;
    idle(8);
    data_ready = 1'b0;
    chk("t2_count", got_q.size(), 4);
    chk_got("t2_b0", 0, 8'h00);
    chk_got("t2_b1", 1, 8'hFF);
    chk_got("t2_b2", 2, 8'h55);
    chk_got("t2_b3", 3, 8'h3C);
    chk("t2_empty", data_valid, 0);

    // 3: framing error, held-low line, then recovery
    clear_stats();
    data_ready = 1'b1;
    send_frame(8'h42, 1'b0);
    idle(64);
    rxd = 1'b1;
    idle(20);
    chk("t3_ferr", n_fe, 1);
    chk("t3_nopush", got_q.size(), 0);
    send_frame(8'h17, 1'b1);
    idle(4);
    chk("t3_count", got_q.size(), 1);
    chk_got("t3_byte", 0, 8'h17);
    chk("t3_ferr_total", n_fe, 1);

    // 4: start glitch, next frame 16 cycles after it began
    clear_stats();
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(12);
    send_frame(8'h6B, 1'b1);
    idle(4);
    chk("t4_count", got_q.size(), 1);
    chk_got("t4_byte", 0, 8'h6B);
    chk("t4_errs", n_fe + n_ov, 0);

    // 5: pop coincides with the push into a full FIFO
    clear_stats();
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    idle(3);
    fork
      send_frame(8'h5E, 1'b1);
      begin
        tgt = cyc + Lat - 1;
        wait (cyc == tgt);
        #1 data_ready = 1'b1;
        @(posedge clock);
        #1 data_ready = 1'b0;
      end
    join
    idle(2);
    chk("t5_overrun", n_ov, 0);
    chk("t5_popped", got_q.size(), 1);
    chk_got("t5_b0", 0, 8'h11);
    data_ready = 1'b1;
    idle(8);
    data_ready = 1'b0;
    chk("t5_count", got_q.size(), 5);
    chk_got("t5_b1", 1, 8'h22);
    chk_got("t5_b2", 2, 8'h33);
    chk_got("t5_b3", 3, 8'h44);
    chk_got("t5_b4", 4, 8'h5E);

    // 6: asynchronous reset during data bit 3
    clear_stats();
    send_frame(8'h99, 1'b1);
    idle(10);
    chk("t6_pre_valid", data_valid, 1);
    send_partial(8'h5A, 3, 5);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", data_valid, 0);
    chk("t6_bits", data_bits, 0);
    chk("t6_ferr", framing_error, 0);
    chk("t6_ovr", overrun, 0);
    rxd = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(20);
    clear_stats();
    data_ready = 1'b1;
    send_frame(8'hC3, 1'b1);
    idle(4);
    chk("t6_count", got_q.size(), 1);
    chk_got("t6_byte", 0, 8'hC3);
    chk("t6_errs", n_fe + n_ov, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

UART receiver (8N1, LSB first) with 16x oversampling, start-bit glitch rejection, framing/overrun detection and a small output FIFO. It sits in the FPGA top-level wrapper next to `SvarogSoC` and decodes a serial line driven by the SoC, such as the currently unused `io_uarts_1_txd`. The decoded bytes go to on-board debug logic (LED/status, a loopback checker) over a ready/valid handshake. It is the receiving end of the SoC's UART transmit path.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Tick divisor is `DIV = CLK_HZ / (BAUD*16)`, truncated, minimum 1.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of 2, ≥2.
- `clock` input 1: the single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rxd` input 1: serial line, idle high, asynchronous to `clock`.
- `data_valid` output 1: FIFO non-empty. `data_bits` holds the oldest byte.
- `data_bits` output 8: oldest received byte.
- `data_ready` input 1: consumer accepts the byte on a cycle with `data_valid && data_ready`.
- `framing_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchronizer:** `rxd` passes through a 2-FF synchronizer, reset value 1. All logic uses the synchronized value `rxs`.
- **Tick generator:**
  - Counter 0..DIV-1; one-cycle `tick` when the count wraps.
  - The counter is cleared on the cycle a start edge is detected, so the first tick comes DIV cycles later.
  - It free-runs otherwise.
- **Oversample counter:** 4 bits, cleared on state entry, increments on each `tick`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rxs==0`, clear the tick and oversample counters and go to START.
  - START: at the 8th tick (mid start bit), go to DATA if `rxs==0`. Otherwise go to IDLE (glitch rejected, no error).
  - DATA: every 16 ticks, shift `rxs` into bit position 0..7, LSB first. After bit 7, go to STOP.
  - STOP: at the 16th tick (mid stop bit):
    - If `rxs==1`, push the byte and go to IDLE.
    - If `rxs==0`, pulse `framing_error`, discard the byte and go to BREAK.
  - BREAK: wait for `rxs==1`, then go to IDLE. This covers a held-low line or break condition, and no bytes are produced.
- **FIFO:** `FIFO_DEPTH` entries, with read/write pointers one bit wider than the address.
  - Pop: `data_valid && data_ready`.
  - Push: a good stop bit is sampled.
  - Push while full with no pop in the same cycle: the byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop and the push both take effect, with no overrun.
  - Push and pop in the same cycle while empty: not possible, because `data_valid` is 0.
- **Reset (any time, including mid-frame):**
  - FSM goes to IDLE; counters, pointers and the shift register are cleared; synchronizer FFs are set to 1.
  - Outputs: `data_valid=0`, `data_bits=0`, `framing_error=0`, `overrun=0`.
  - Any partial frame is lost. A frame already in progress on the line when reset is released may be decoded as garbage or flagged as a framing error. This is acceptable.

## Timing
- Synchronizer latency is 2 cycles from the `rxd` edge to `rxs`.
- Bit period is 16·DIV cycles. The sample points are at 8·DIV + n·16·DIV cycles after start detection, for n = 1..8 data bits and n = 9 for the stop bit.
- `data_valid` rises the cycle after the stop-bit sample, i.e. 152·DIV + 3 cycles (±1) after the `rxd` falling edge.
- `data_bits` is registered and stable while `data_valid && !data_ready`.
- Once data is in the FIFO, `data_valid` is asserted independently of `data_ready`.
- `framing_error` and `overrun` are registered pulses issued on the cycle after the stop-bit sample.
- The next start bit is accepted from the first cycle in IDLE, which comes after the mid-stop sample. This allows back-to-back frames at full line rate.
- Baud error tolerance follows from the 16x mid-bit sampling: ±3% total.

## Test plan
Benches use `CLK_HZ=1_600_000`, `BAUD=100_000`, giving DIV=1 and 16 cycles per bit.
1. **Single byte, consumer ready:** send 0xA5 with `data_ready=1` -> `data_bits=0xA5` and `data_valid` high for exactly 1 cycle, 155±1 cycles after the falling edge. No error pulses.
2. **Back-to-back burst:** send 0x00, 0xFF, 0x55, 0x3C, 0x81 back-to-back with `data_ready=0` -> first four bytes held in order, one `overrun` pulse on the fifth. Then raise `data_ready` -> 0x00, 0xFF, 0x55, 0x3C are popped, then `data_valid=0`.
3. **Framing error:** send 0x42 with the stop bit low, then hold `rxd` low for 64 cycles, then release -> one `framing_error` pulse, no push, FSM stays in BREAK until high. A following 0x17 is received correctly.
4. **Start glitch:** 4-cycle low pulse on `rxd` -> no byte, no error; FSM back in IDLE before the 16th cycle.
5. **Simultaneous push and pop when full:** fill the FIFO with 4 bytes, then time a pop on the same cycle as the 5th byte's push -> no `overrun`, FIFO keeps 4 entries, and the 5th byte is last out.
6. **Reset mid-frame:** assert `reset` during DATA bit 3 of a frame -> all outputs 0 immediately (asynchronous). After release, with the line idle, a new frame 0xC3 is received correctly.
